adder_share_arb: RTL and testbench
==================================

// Module: adder_share_arb
// PURPOSE
//  Shares one 8-bit prefix adder instance (module adder, 8-bit a/b -> s, no carry-in/out)
//  between NREQ requesters using round-robin arbitration and a valid/ready handshake.
//  The sum is captured in a one-entry output register with backpressure.
//  Sits between operand producers and a single shared result consumer.
// PARAMETERS
//  NREQ  4   number of requesters; legal range 2..16
//  IDW   2   rsp_id width; must equal $clog2(NREQ)
//  CNTW  16  width of the completed-transaction counter
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         synchronous reset, active-low
//  req_valid  in   NREQ      requester i holds operands valid
//  req_ready  out  NREQ      one-hot grant; handshake for i completes when valid[i]&ready[i]
//  req_a      in   NREQ*8    operand A, requester i occupies bits [8i+7:8i]
//  req_b      in   NREQ*8    operand B, same packing
//  rsp_valid  out  1         output register holds a result
//  rsp_ready  in   1         consumer accepts the result
//  rsp_sum    out  8         (a+b) mod 256 from the shared adder; carry is discarded
//  rsp_id     out  IDW       index of the requester that owns rsp_sum
//  done_cnt   out  CNTW      count of results accepted by consumer; wraps modulo 2^CNTW
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): rsp_valid=0, rsp_sum=0, rsp_id=0, done_cnt=0,
//    rr_ptr=0, state=EMPTY. req_ready is all-zero while rst_n=0.
//    Reset mid-operation discards any held result; no partial handshake survives.
//  - FSM on the output register:
//    EMPTY: rsp_valid=0. If any req_valid, grant and capture -> FULL.
//    FULL: rsp_valid=1. On rsp_ready: if any req_valid, grant and capture -> FULL,
//          else -> EMPTY. On !rsp_ready: hold rsp_sum/rsp_id and stay FULL with no grant.
//  - can_accept = (state==EMPTY) | rsp_ready. req_ready is combinational and
//    nonzero only when can_accept and at least one req_valid. Full throughput:
//    one result per cycle while the consumer holds rsp_ready=1.
//  - Arbitration: requester i is granted when it is the first valid index scanning
//    rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ. On a grant to i, rr_ptr <= (i+1) mod NREQ.
//    rr_ptr is unchanged on cycles with no grant.
//  - Datapath: the granted requester's a/b are muxed into one adder instance.
//    At the grant edge, rsp_sum <= s and rsp_id <= i. Latency is 1 cycle from
//    the grant to rsp_valid.
//  - Requester rules: a requester keeps valid and its operands stable until it is granted.
//    The block does not check this; dropping valid early is legal and simply forfeits the turn.
//  - done_cnt increments by 1 on every cycle with rsp_valid & rsp_ready. Its last value
//    2^CNTW-1 is followed by 0.
//  - Simultaneous drain and refill in FULL: both happen in the same cycle. The new result
//    replaces the old one with no bubble, and done_cnt still increments.
//  - rsp_ready while EMPTY has no effect. Operand values never affect the arbitration.
// TESTING
//  1 Reset: hold rst_n=0 for 3 clks with all req_valid=1 -> req_ready=0, rsp_valid=0,
//    done_cnt=0. Release reset -> first grant goes to req 0.
//  2 Single add: req1 a=8'h3C b=8'h05, rsp_ready=1 -> next cycle rsp_valid=1,
//    rsp_sum=8'h41, rsp_id=1. done_cnt=1 one cycle later.
//  3 Wrap/carry drop: a=8'hFF b=8'h02 -> rsp_sum=8'h01.
//    a=8'h80 b=8'h80 -> rsp_sum=8'h00.
//  4 Round-robin: all 4 requesters valid continuously, rsp_ready=1 ->
//    rsp_id sequence 0,1,2,3,0,1 with one result per clk.
//  5 Backpressure: FULL with rsp_ready=0 for 5 clks while req2 is valid -> req_ready=0,
//    rsp_sum/rsp_id stable. On rsp_ready=1, req2 is granted the same cycle with no bubble.
//  6 Counter wrap (CNTW=4): 17 accepted results -> done_cnt=1.
//    Also assert rst_n=0 while FULL -> rsp_valid=0 next cycle.

Source files
------------

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one 8-bit prefix adder among NREQ
// requesters, with a one-entry result register that supports backpressure.
// Also holds the shared adder itself (module adder).

// 8-bit Kogge-Stone adder; the carry-out is dropped, so s = (a + b) mod 256.
module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s
);
    logic [7:0] g0, p0, g1, p1, g2, p2, g3;

    // Bit-level generate/propagate.
    assign g0 = a & b;
    assign p0 = a ^ b;

    // Prefix levels with spans 1, 2 and 4. Zeros shift in below bit 0
    // because there is no carry-in.
    assign g1 = g0 | (p0 & {g0[6:0], 1'b0});
    assign p1 = p0 & {p0[6:0], 1'b0};
    assign g2 = g1 | (p1 & {g1[5:0], 2'b00});
    assign p2 = p1 & {p1[5:0], 2'b00};
    assign g3 = g2 | (p2 & {g2[3:0], 4'b0000});

    // The carry into bit i is the group generate of bits i-1..0.
    assign s = p0 ^ {g3[6:0], 1'b0};
endmodule

module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_sum,
    output logic [IDW-1:0]    rsp_id,
    output logic [CNTW-1:0]   done_cnt
);
    localparam int unsigned NREQ_U = NREQ;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]      rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [CNTW-1:0] done_cnt_q, done_cnt_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic            can_accept;
    logic            do_grant;
    logic            out_fire;
    logic [7:0]      op_a, op_b, sum;

    // (base + off) mod NREQ, for off < NREQ; works for non-power-of-two NREQ.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int unsigned    off);
        int unsigned t;
        t = 32'(base) + off;
        if (t >= NREQ_U) t = t - NREQ_U;
        return IDW'(t);
    endfunction

    // Round-robin pick: first valid requester scanning upward from rr_ptr.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_idx(rr_ptr_q, k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Handshake qualifiers; reset gates the grant so nothing is accepted
    // while rst_n is low.
    always_comb begin
        can_accept = (state_q == EMPTY) || rsp_ready;
        do_grant   = rst_n && can_accept && grant_found;
        out_fire   = (state_q == FULL) && rsp_ready;
        req_ready  = do_grant ? (NREQ'(1) << grant_idx) : '0;
    end

    // Operand mux in front of the single shared adder.
    always_comb begin
        op_a = req_a[{grant_idx, 3'b000} +: 8];
        op_b = req_b[{grant_idx, 3'b000} +: 8];
    end

    adder u_adder (
        .a (op_a),
        .b (op_b),
        .s (sum)
    );

    // Next-state for the output register, pointer and counter. A drain and
    // a refill in the same cycle both take effect, so FULL stays FULL.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_id_d   = rsp_id_q;
        done_cnt_d = done_cnt_q;
        if (out_fire) begin
            done_cnt_d = done_cnt_q + CNTW'(1);
            state_d    = EMPTY;
        end
        if (do_grant) begin
            state_d   = FULL;
            rsp_sum_d = sum;
            rsp_id_d  = grant_idx;
            rr_ptr_d  = wrap_idx(grant_idx, 1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values; blocking would create order-dependent races.
        if (!rst_n) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_id_q   <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_id_q   <= rsp_id_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_adder_share_arb.sv
// Directed testbench for adder_share_arb (NREQ=4, CNTW=4 so the counter wrap
// is reachable in a few cycles).
module tb_adder_share_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic [CNTW-1:0]   done_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    adder_share_arb #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n     = 1'b1;
        settle();
    endtask

    logic [7:0] rr_sum_tbl [6];

    initial begin
        rr_sum_tbl[0] = 8'h11; rr_sum_tbl[1] = 8'h22; rr_sum_tbl[2] = 8'h33;
        rr_sum_tbl[3] = 8'h44; rr_sum_tbl[4] = 8'h11; rr_sum_tbl[5] = 8'h22;

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #2;

        // 1: reset held 3 clocks with every requester valid
        req_valid = 4'hF;
        repeat (3) step();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_done_cnt",  done_cnt,  0);
        check("rst_rsp_sum",   rsp_sum,   0);
        rst_n = 1'b1;
        settle();
        check("rst_first_grant", req_ready, 4'b0001);
        step();
        check("rst_first_valid", rsp_valid, 1);
        check("rst_first_id",    rsp_id,    0);

        // 2: single add from requester 1
        do_reset();
        req_a = {8'h00, 8'h00, 8'h3C, 8'h00};
        req_b = {8'h00, 8'h00, 8'h05, 8'h00};
        req_valid = 4'b0010; rsp_ready = 1'b1;
        settle();
        check("single_grant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        check("single_valid", rsp_valid, 1);
        check("single_sum",   rsp_sum,   8'h41);
        check("single_id",    rsp_id,    1);
        check("single_cnt0",  done_cnt,  0);
        step();
        check("single_cnt1",  done_cnt,  1);
        check("single_empty", rsp_valid, 0);

        // 3: carry is discarded (rr_ptr is now 2)
        req_a = {8'h80, 8'hFF, 8'h00, 8'h00};
        req_b = {8'h80, 8'h02, 8'h00, 8'h00};
        req_valid = 4'b0100;
        step();
        req_valid = 4'b1000;
        check("carry_ff02_sum", rsp_sum, 8'h01);
        check("carry_ff02_id",  rsp_id,  2);
        settle();
        check("carry_refill_grant", req_ready, 4'b1000);
        step();
        req_valid = '0;
        check("carry_8080_sum", rsp_sum, 8'h00);
        check("carry_8080_id",  rsp_id,  3);
        check("carry_cnt2",     done_cnt, 2);
        step();
        check("carry_cnt3",     done_cnt, 3);
        check("carry_empty",    rsp_valid, 0);

        // 4: round-robin with all requesters valid, one result per clock
        do_reset();
        req_a = {8'h40, 8'h30, 8'h20, 8'h10};
        req_b = {8'h04, 8'h03, 8'h02, 8'h01};
        req_valid = 4'hF; rsp_ready = 1'b1;
        settle();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_grant%0d", k), req_ready, 32'(1) << (k % 4));
            step();
            check($sformatf("rr_valid%0d", k), rsp_valid, 1);
            check($sformatf("rr_id%0d", k),    rsp_id,    k % 4);
            check($sformatf("rr_sum%0d", k),   rsp_sum,   rr_sum_tbl[k]);
        end
        req_valid = '0;
        step();
        check("rr_cnt6", done_cnt, 6);

        // 5: backpressure while requester 2 waits
        do_reset();
        req_a = {8'h00, 8'h0A, 8'h00, 8'h01};
        req_b = {8'h00, 8'h0B, 8'h00, 8'h01};
        req_valid = 4'b0001; rsp_ready = 1'b0;
        step();
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("bp_ready%0d", k), req_ready, 0);
            check($sformatf("bp_sum%0d", k),   rsp_sum,   8'h02);
            check($sformatf("bp_id%0d", k),    rsp_id,    0);
            check($sformatf("bp_valid%0d", k), rsp_valid, 1);
            step();
        end
        check("bp_cnt_hold", done_cnt, 0);
        rsp_ready = 1'b1;
        settle();
        check("bp_release_grant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        check("bp_new_valid", rsp_valid, 1);
        check("bp_new_sum",   rsp_sum,   8'h15);
        check("bp_new_id",    rsp_id,    2);
        check("bp_cnt1",      done_cnt,  1);
        step();
        check("bp_cnt2",      done_cnt,  2);

        // EMPTY with rsp_ready=1 and nothing valid: counter unchanged
        step();
        check("empty_ready_noop", done_cnt, 2);

        // 6: counter wrap at CNTW=4, then reset while FULL
        do_reset();
        req_a = '0; req_b = '0;
        req_valid = 4'hF; rsp_ready = 1'b1;
        repeat (17) step();
        check("wrap_cnt_16", done_cnt, 0);
        req_valid = '0;
        step();
        check("wrap_cnt_17", done_cnt, 1);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        step();
        check("full_before_rst", rsp_valid, 1);
        rst_n = 1'b0;
        settle();
        check("rst_mid_ready", req_ready, 0);
        step();
        check("rst_mid_valid", rsp_valid, 0);
        check("rst_mid_cnt",   done_cnt,  0);
        rst_n = 1'b1;
        req_valid = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
